// File: rtl/pcm_req_pkg.sv
// Shared constants for the PCM output requantizer.
// Holds the default widths, shift and FIFO depth, the clip counter width,
// and helpers that produce signed saturation limits for a given word width.
package pcm_req_pkg;

  localparam int unsigned DEF_IN_WIDTH   = 50;
  localparam int unsigned DEF_OUT_WIDTH  = 24;
  localparam int unsigned DEF_SHIFT      = 20;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  localparam int unsigned CLIP_CNT_W = 16;
  localparam logic [CLIP_CNT_W-1:0] CLIP_CNT_MAX = '1;

  // Largest value of a signed w-bit word, sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value of a signed w-bit word, sign-extended to 64 bits.
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/pcm_req_fifo.sv
// Synchronous FIFO with registered head data, valid, full and level.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   push_i      : write wdata_i (caller guarantees room, or a pop in the same cycle)
//   pop_i       : advance the head (caller guarantees valid_o)
//   wdata_i     : write data
//   rdata_o     : head sample, held while no pop occurs
//   valid_o     : FIFO not empty
//   full_o      : FIFO holds DEPTH entries
//   level_o     : current occupancy
module pcm_req_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    valid_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;

  // Next pointers and registered flags; pointers carry an extra wrap bit.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    level_d  = wr_ptr_d - rd_ptr_d;
    valid_d  = (wr_ptr_d != rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    rdata_d  = rdata_q;
    if (valid_d) begin
      // The new head may be the word being written this very cycle.
      if (push_i && (wr_ptr_q == rd_ptr_d)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && push_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign level_o = level_q;

endmodule

// File: rtl/pcm_output_requantizer.sv
// PCM output requantizer: round-half-up right shift, saturation to OUT_WIDTH,
// and a small output FIFO with valid/ready drain plus sticky status.
// Optional feature macro: PCM_REQ_CLIP_CNT_EN builds the 16-bit clip counter;
// without it clip_count is tied to zero.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid, in_data   : one-cycle sample strobe and signed input sample
//   out_valid, out_ready: FIFO head handshake
//   out_data            : signed requantized head sample
//   fifo_level          : FIFO occupancy
//   clip, overflow      : sticky saturation / sample-drop flags
//   clr_status          : clears clip, overflow and clip_count
//   clip_count          : saturating count of clipped samples
module pcm_output_requantizer
  import pcm_req_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned SHIFT      = DEF_SHIFT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [IN_WIDTH-1:0]           in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          clip,
  output logic                          overflow,
  input  logic                          clr_status,
  output logic [CLIP_CNT_W-1:0]         clip_count
);

  localparam int unsigned RW = IN_WIDTH + 1;

  localparam logic signed [RW-1:0]  RND     = RW'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [RW-1:0]  SAT_MAX = RW'(sat_max(OUT_WIDTH));
  localparam logic signed [RW-1:0]  SAT_MIN = RW'(sat_min(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0]  OUT_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0]  OUT_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));

  // Stage 1: sign-extend by one bit so adding the half-LSB cannot overflow.
  logic signed [RW-1:0] in_ext, sum, r_d, r_q;
  logic                 v1_q;

  always_comb begin
    in_ext = {in_data[IN_WIDTH-1], in_data};
    sum    = in_ext + RND;
    r_d    = sum >>> SHIFT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      v1_q <= in_valid;
    end
  end

  // Stage 2: clamp to the signed output range.
  logic [OUT_WIDTH-1:0] s2_d, s2_q;
  logic                 clipped;
  logic                 v2_q, sat_q;

  always_comb begin
    s2_d    = r_q[OUT_WIDTH-1:0];
    clipped = 1'b0;
    if (r_q > SAT_MAX) begin
      s2_d    = OUT_MAX;
      clipped = 1'b1;
    end else if (r_q < SAT_MIN) begin
      s2_d    = OUT_MIN;
      clipped = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_q  <= '0;
      v2_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      s2_q  <= s2_d;
      v2_q  <= v1_q;
      sat_q <= v1_q & clipped;
    end
  end

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  logic fifo_full;
  logic pop_c, push_c;

  assign pop_c  = out_valid & out_ready;
  assign push_c = v2_q & (~fifo_full | pop_c);

  pcm_req_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (s2_q),
    .rdata_o (out_data),
    .valid_o (out_valid),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  // Sticky flags: a set in the same cycle as a clear wins.
  logic clip_q, clip_d, ovf_q, ovf_d;

  always_comb begin
    clip_d = clip_q;
    ovf_d  = ovf_q;
    if (clr_status) begin
      clip_d = 1'b0;
      ovf_d  = 1'b0;
    end
    if (sat_q) begin
      clip_d = 1'b1;
    end
    if (v2_q && !push_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clip_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      clip_q <= clip_d;
      ovf_q  <= ovf_d;
    end
  end

  assign clip     = clip_q;
  assign overflow = ovf_q;

`ifdef PCM_REQ_CLIP_CNT_EN
  // Saturating clip counter; a clear coincident with a clip loads one.
  logic [CLIP_CNT_W-1:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (clr_status) begin
      clip_cnt_d = CLIP_CNT_W'(sat_q);
    end else if (sat_q && (clip_cnt_q != CLIP_CNT_MAX)) begin
      clip_cnt_d = clip_cnt_q + CLIP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_count = clip_cnt_q;
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_pcm_output_requantizer.sv
// Self-checking bench for pcm_output_requantizer: directed scenarios with
// literal expectations plus a randomized run, all checked every cycle against
// a queue-based behavioural model.
module tb_pcm_output_requantizer;

  localparam int IW = 50;
  localparam int OW = 24;
  localparam int SH = 20;
  localparam int D  = 8;
  localparam int LW = 4;
  localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW - 1));

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [LW-1:0] fifo_level;
  logic          clip;
  logic          overflow;
  logic          clr_status;
  logic [15:0]   clip_count;

  int checks = 0;
  int errors = 0;

  pcm_output_requantizer #(
    .IN_WIDTH   (IW),
    .OUT_WIDTH  (OW),
    .SHIFT      (SH),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .clip       (clip),
    .overflow   (overflow),
    .clr_status (clr_status),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer round-half-up division by 2^SH, then clamp.
  function automatic longint requant(input logic [IW-1:0] x, output logic clipped);
    longint s, r;
    s = longint'($signed(x));
    r = (s + (64'sd1 <<< (SH - 1))) >>> SH;
    clipped = (r > OMAX) || (r < OMIN);
    if (r > OMAX) r = OMAX;
    else if (r < OMIN) r = OMIN;
    return r;
  endfunction

  // Behavioural model: two-cycle delay line feeding a bounded queue.
  longint mq[$];
  logic   pv[2];
  longint pd[2];
  logic   pc[2];
  logic   m_clip, m_ovf;
  int     m_cnt;
  longint m_data;
  logic   m_pop, m_acc, m_c;
  int     m_sz;
  longint m_v;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        pv[0] = 1'b0; pv[1] = 1'b0; pc[0] = 1'b0; pc[1] = 1'b0;
        pd[0] = 0; pd[1] = 0;
        m_clip = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_data = 0;
      end else begin
        m_sz  = mq.size();
        m_pop = (m_sz > 0) && out_ready;
        m_acc = pv[1] && ((m_sz < D) || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (m_acc) mq.push_back(pd[1]);
        if (pv[1] && !m_acc) m_ovf = 1'b1;
        else if (clr_status) m_ovf = 1'b0;
        if (pc[1]) m_clip = 1'b1;
        else if (clr_status) m_clip = 1'b0;
        if (clr_status) m_cnt = pc[1] ? 1 : 0;
        else if (pc[1] && m_cnt < 65535) m_cnt = m_cnt + 1;
        pv[1] = pv[0]; pd[1] = pd[0]; pc[1] = pc[0];
        m_v   = requant(in_data, m_c);
        pv[0] = in_valid; pd[0] = m_v; pc[0] = in_valid && m_c;
        if (mq.size() > 0) m_data = mq[0];
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", longint'(out_valid), longint'(mq.size() > 0));
      if (mq.size() > 0) chk("out_data", $signed(out_data), m_data);
      chk("fifo_level", longint'(fifo_level), longint'(mq.size()));
      chk("clip", longint'(clip), longint'(m_clip));
      chk("overflow", longint'(overflow), longint'(m_ovf));
`ifdef PCM_REQ_CLIP_CNT_EN
      chk("clip_count", longint'(clip_count), longint'(m_cnt));
`else
      chk("clip_count", longint'(clip_count), 0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input longint x);
    in_valid = 1'b1;
    in_data  = IW'(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic pop_expect(input longint exp, input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk(name, $signed(out_data), exp);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  function automatic logic [IW-1:0] rand_sample();
    longint x;
    int     sel;
    sel = int'($urandom_range(0, 3));
    if (sel == 3) begin
      x = (longint'($urandom_range(0, 20000)) - 10000) * (64'sd1 <<< SH)
          + (64'sd1 <<< (SH - 1)) + longint'($urandom_range(0, 2)) - 1;
    end else begin
      x = longint'({$urandom, $urandom}) >>> $urandom_range(14, 40);
    end
    return IW'(x);
  endfunction

  longint exp_cnt2, exp_cnt1;

  initial begin
`ifdef PCM_REQ_CLIP_CNT_EN
    exp_cnt2 = 2; exp_cnt1 = 1;
`else
    exp_cnt2 = 0; exp_cnt1 = 0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_status = 1'b0;
    tick(2);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_level", longint'(fifo_level), 0);
    chk("rst_clip", longint'(clip), 0);
    chk("rst_overflow", longint'(overflow), 0);
    chk("rst_clip_count", longint'(clip_count), 0);
    rst_n = 1'b1;
    tick(1);

    // Rounding and latency
    send(3 * (64'sd1 <<< 19));
    tick(1);
    chk("latency_n2", longint'(out_valid), 0);
    tick(1);
    chk("latency_n3", longint'(out_valid), 1);
    send(-3 * (64'sd1 <<< 19));
    send((64'sd1 <<< 19) - 1);
    send(-(64'sd1 <<< 19));
    tick(3);
    pop_expect(2, "round_3h");
    pop_expect(-1, "round_m3h");
    pop_expect(0, "round_h_m1");
    pop_expect(0, "round_mh");
    chk("round_clip", longint'(clip), 0);

    // Saturation
    send(64'sd1 <<< 43);
    send(-(64'sd1 <<< 44));
    tick(3);
    pop_expect(8388607, "sat_pos");
    pop_expect(-8388608, "sat_neg");
    chk("sat_clip", longint'(clip), 1);
    chk("sat_count", longint'(clip_count), exp_cnt2);

    // Clear coincident with a clipped sample at stage 2
    send(64'sd1 <<< 43);
    tick(1);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    chk("race_clip", longint'(clip), 1);
    chk("race_count", longint'(clip_count), exp_cnt1);
    pop_expect(8388607, "race_data");

    // Backpressure and overflow
    pulse_clr();
    for (int k = 1; k <= 8; k++) send(longint'(k) <<< SH);
    tick(3);
    chk("bp_level", longint'(fifo_level), 8);
    chk("bp_ovf0", longint'(overflow), 0);
    send(64'sd9 <<< SH);
    tick(3);
    chk("bp_ovf1", longint'(overflow), 1);
    chk("bp_level_after", longint'(fifo_level), 8);
    for (int k = 1; k <= 8; k++) pop_expect(longint'(k), "bp_drain");

    // Full with simultaneous push and pop
    pulse_clr();
    for (int k = 1; k <= 8; k++) send(longint'(k) <<< SH);
    tick(3);
    chk("full_level", longint'(fifo_level), 8);
    send(64'sd9 <<< SH);
    tick(1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("full_pp_level", longint'(fifo_level), 8);
    chk("full_pp_ovf", longint'(overflow), 0);
    for (int k = 2; k <= 9; k++) pop_expect(longint'(k), "full_pp_drain");

    // Reset mid-stream
    send(64'sd1 <<< 43);
    for (int k = 1; k <= 4; k++) send(longint'(k) <<< SH);
    tick(3);
    chk("mid_level5", longint'(fifo_level), 5);
    chk("mid_clip", longint'(clip), 1);
    send(64'sd7 <<< SH);
    send(64'sd8 <<< SH);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_level", longint'(fifo_level), 0);
    chk("mid_rst_clip", longint'(clip), 0);
    chk("mid_rst_ovf", longint'(overflow), 0);
    chk("mid_rst_count", longint'(clip_count), 0);
    out_ready = 1'b1;
    tick(10);
    chk("mid_no_stale", longint'(out_valid), 0);
    out_ready = 1'b0;

    // Randomized traffic with alternating drain-rate phases
    for (int i = 0; i < 4000; i++) begin
      in_valid   = ($urandom_range(0, 9) < 6);
      in_data    = rand_sample();
      out_ready  = ((i % 1000) < 500) ? ($urandom_range(0, 9) < 8)
                                      : ($urandom_range(0, 9) < 2);
      clr_status = ($urandom_range(0, 49) == 0);
      rst_n      = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; clr_status = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    tick(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_output_requantizer.md
# pcm_output_requantizer

Final stage of the decimation chain: consumes the 50-bit signed PCM stream from the decimation filter, rescales it by an arithmetic right shift with round-half-up, saturates to the output word width, and buffers the samples in a small FIFO drained through a valid/ready handshake. The decimation chain has no backpressure, so this block absorbs downstream stalls up to the FIFO depth and flags sample loss and clipping with sticky status bits.

## Interface
- `IN_WIDTH`, 50: input sample width (signed).
- `OUT_WIDTH`, 24: output sample width (signed).
- `SHIFT`, 20: right-shift amount. Legal range is 1 to IN_WIDTH-2.
- `FIFO_DEPTH`, 8: number of buffered samples. Must be a power of two, at least 2.

Ports:
- `clk` input, 1 bit: single clock.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `in_valid` input, 1 bit: sample strobe from the decimation chain (one cycle per sample).
- `in_data` input, IN_WIDTH bits: signed sample.
- `out_valid` output, 1 bit: FIFO head is valid.
- `out_ready` input, 1 bit: consumer accepts the head sample.
- `out_data` output, OUT_WIDTH bits: signed requantized sample.
- `fifo_level` output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
- `clip` output, 1 bit: sticky flag; a sample was saturated.
- `overflow` output, 1 bit: sticky flag; a sample was dropped because the FIFO was full.
- `clr_status` input, 1 bit: clears the `clip` and `overflow` flags and `clip_count`.
- `clip_count` output, 16 bits: saturating count of clipped samples.

## Operation
- **Stage 1 (round):**
  - Compute `r = (sext(in_data, IN_WIDTH+1) + 2^(SHIFT-1)) >>> SHIFT`, an arithmetic shift that yields a round-half-up result.
  - Register `r` and `v1 = in_valid`.
- **Stage 2 (saturate):**
  - If `r > 2^(OUT_WIDTH-1)-1`, output the max value.
  - If `r < -2^(OUT_WIDTH-1)`, output the min value.
  - Otherwise output `r` truncated to OUT_WIDTH.
  - Register the result, with `v2 = v1` and `sat = v1 & clipped`.
- **FIFO write:** on `v2`, write if `!full || pop`, where `pop = out_valid & out_ready`. Otherwise drop the sample and set `overflow`.
- **FIFO read:** `pop` advances the head. `out_data` holds its value while `out_valid & !out_ready`.
- **Simultaneous push and pop at full:** both occur; the level is unchanged.
- **Simultaneous push and pop at empty:** the push is accepted, no pop happens, and the level becomes 1.
- **Status flags:**
  - `clip` sets on `sat`.
  - `clr_status` clears both flags.
  - If a set and `clr_status` occur in the same cycle, the set wins.
- **Clip counter:** `clip_count` increments on `sat` and saturates at 0xFFFF. `clr_status` zeroes it; if an increment happens in the same cycle, the counter loads 1.
- **Pointer wrap:** pointers wrap modulo FIFO_DEPTH. Full and empty are derived from the extra pointer MSB.

## Timing
- **Reset values:** `out_valid` 0, `out_data` 0, `fifo_level` 0, `clip` 0, `overflow` 0, `clip_count` 0. Pipeline valids are cleared and the FIFO is emptied.
- **Reset mid-operation:** in-flight and buffered samples are discarded.
- **Latency:** an `in_valid` at cycle N into an empty FIFO gives `out_valid` at cycle N+3 (two pipeline registers plus the FIFO write).
- **Throughput:** one sample per cycle accepted. No `in_ready` is provided.
- **`fifo_level` update:** updates in the cycle after a push or pop.

## Configuration
- `PCM_REQ_CLIP_CNT_EN` defined: the 16-bit clip counter is implemented as described above.
- Not defined: no counter logic is built, and `clip_count` is constant 0. The `clip` flag is unaffected.

## Structure
- **Package `pcm_req_pkg`:** default width, shift and depth constants; `CLIP_CNT_W = 16`; saturation limit helper constants.
- **Sub-module `pcm_req_fifo`:** a synchronous FIFO with push, pop, full, empty and level signals, registered output and synchronous active-low reset.
- **Top level:** round/saturate pipeline plus status logic.

## Test plan
All scenarios use SHIFT=20 and OUT_WIDTH=24.

- **Rounding:** `in_data` = 3·2^19 gives `out_data` 2; −3·2^19 gives −1; 2^19−1 gives 0; −2^19 gives 0. `clip` stays 0. First `out_valid` appears 3 cycles after `in_valid`.
- **Saturation:** `in_data` = 2^43 gives 8388607; −2^44 gives −8388608. `clip` goes to 1, and `clip_count` = 2 when the macro is defined, 0 when it is not.
- **Backpressure:**
  - Setup: hold `out_ready`=0 and push 8 samples (values 1..8 ×2^20).
  - Expected: `fifo_level` = 8 and `overflow` = 0.
  - Then push a 9th sample: it is dropped and `overflow` = 1.
  - Then drain: outputs are 1..8 in order.
- **Full plus simultaneous push/pop:** with the FIFO full, `out_ready`=1 and `v2` in the same cycle: the sample is accepted, `fifo_level` stays 8 and `overflow` stays 0.
- **Status clear race:** `clr_status` in the same cycle as a clipped sample at stage 2: `clip` = 1 and `clip_count` = 1.
- **Reset mid-stream:** `rst_n`=0 for one cycle with 5 samples buffered. Next cycle: `out_valid`=0, `fifo_level`=0, all flags 0, and no stale sample appears afterwards.
